// File: rtl/i2c_pkg.sv
// Shared encodings for the byte-level I2C master: FSM states, quarter phases,
// byte indices, RW encoding and the latched request record.
package i2c_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_SEND_BIT  = 3'd2;
    localparam logic [2:0] ST_GET_ACK   = 3'd3;
    localparam logic [2:0] ST_RESTART   = 3'd4;
    localparam logic [2:0] ST_RECV_BIT  = 3'd5;
    localparam logic [2:0] ST_SEND_NACK = 3'd6;
    localparam logic [2:0] ST_STOP      = 3'd7;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic [1:0] BYTE_ADDR = 2'd0;
    localparam logic [1:0] BYTE_REG  = 2'd1;
    localparam logic [1:0] BYTE_DATA = 2'd2;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    typedef struct packed {
        logic       rw;
        logic [6:0] dev_addr;
        logic [7:0] reg_addr;
        logic [7:0] wr_data;
    } i2c_req_t;

    // On a read, the DATA slot carries the repeated address byte with R set.
    function automatic logic [7:0] tx_byte(input i2c_req_t req, input logic [1:0] idx);
        logic [7:0] result;
        case (idx)
            BYTE_ADDR: result = {req.dev_addr, RW_WRITE};
            BYTE_REG:  result = req.reg_addr;
            default:   result = (req.rw == RW_READ) ? {req.dev_addr, RW_READ} : req.wr_data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: one-cycle pulse every CLK_DIV clocks,
// held at zero while restart is asserted.
module i2c_tick_gen #(
    parameter int CLK_DIV = 125
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = !i_restart && (r_cnt == LAST);

endmodule

// File: rtl/i2c_main_sm.sv
// Byte-level I2C master: runs one register write or register read per START,
// driving open-drain SCL/SDA in four quarter-period phases per bit.
module i2c_main_sm
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 125
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_rw,
    input  logic [6:0] i_dev_addr,
    input  logic [7:0] i_reg_addr,
    input  logic [7:0] i_wr_data,
    output logic       o_busy,
    output logic [7:0] o_rd_data,
    output logic       o_ack_err,
    input  logic       i_sda_in,
    output logic       o_scl_oe,
    output logic       o_sda_oe
);

    logic [2:0] r_state;
    logic [1:0] r_phase;
    logic [2:0] r_bit;
    logic [1:0] r_byte;
    i2c_req_t   r_req;
    logic       r_nack;
    logic [7:0] r_rx;
    logic [7:0] r_rd_data;
    logic       r_ack_err;
    logic       r_armed;

    logic       w_tick;
    logic       w_accept;
    logic [7:0] w_tx_byte;
    logic       w_tx_bit;
    logic       w_scl_oe;
    logic       w_sda_oe;

    i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (r_state == ST_IDLE),
        .o_tick    (w_tick)
    );

    // A START still high when the engine returns to IDLE must drop once first.
    assign w_accept  = (r_state == ST_IDLE) && i_start && r_armed;
    assign w_tx_byte = tx_byte(r_req, r_byte);
    assign w_tx_bit  = w_tx_byte[r_bit];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_phase   <= Q0;
            r_bit     <= 3'd7;
            r_byte    <= BYTE_ADDR;
            r_req     <= '0;
            r_nack    <= 1'b0;
            r_rx      <= 8'h00;
            r_rd_data <= 8'h00;
            r_ack_err <= 1'b0;
            r_armed   <= 1'b1;
        end else begin
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (!i_start) begin
                r_armed <= 1'b1;
            end

            if (w_accept) begin
                r_req     <= '{rw: i_rw, dev_addr: i_dev_addr, reg_addr: i_reg_addr, wr_data: i_wr_data};
                r_ack_err <= 1'b0;
                r_state   <= ST_START;
                r_phase   <= Q0;
            end else if (w_tick) begin
                if (r_phase == Q1 && r_state == ST_GET_ACK) begin
                    r_nack <= i_sda_in;
                end
                if (r_phase == Q1 && r_state == ST_RECV_BIT) begin
                    r_rx <= {r_rx[6:0], i_sda_in};
                end
                r_phase <= r_phase + 2'd1;

                if (r_phase == Q3) begin
                    case (r_state)
                        ST_START: begin
                            r_state <= ST_SEND_BIT;
                            r_byte  <= BYTE_ADDR;
                            r_bit   <= 3'd7;
                        end
                        ST_RESTART: begin
                            r_state <= ST_SEND_BIT;
                            r_byte  <= BYTE_DATA;
                            r_bit   <= 3'd7;
                        end
                        ST_SEND_BIT: begin
                            if (r_bit == 3'd0) begin
                                r_state <= ST_GET_ACK;
                            end else begin
                                r_bit <= r_bit - 3'd1;
                            end
                        end
                        ST_GET_ACK: begin
                            r_bit <= 3'd7;
                            if (r_nack) begin
                                r_ack_err <= 1'b1;
                                r_state   <= ST_STOP;
                            end else begin
                                case (r_byte)
                                    BYTE_ADDR: begin
                                        r_state <= ST_SEND_BIT;
                                        r_byte  <= BYTE_REG;
                                    end
                                    BYTE_REG: begin
                                        if (r_req.rw == RW_READ) begin
                                            r_state <= ST_RESTART;
                                        end else begin
                                            r_state <= ST_SEND_BIT;
                                            r_byte  <= BYTE_DATA;
                                        end
                                    end
                                    default: begin
                                        r_state <= (r_req.rw == RW_READ) ? ST_RECV_BIT : ST_STOP;
                                    end
                                endcase
                            end
                        end
                        ST_RECV_BIT: begin
                            if (r_bit == 3'd0) begin
                                r_state   <= ST_SEND_NACK;
                                r_rd_data <= r_rx;
                            end else begin
                                r_bit <= r_bit - 3'd1;
                            end
                        end
                        ST_SEND_NACK: r_state <= ST_STOP;
                        default:      r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Line drive per state and quarter; SDA only ever changes while SCL is low,
    // except inside the S/Sr/P conditions.
    always_comb begin
        w_scl_oe = 1'b0;
        w_sda_oe = 1'b0;
        case (r_state)
            ST_START: begin
                w_scl_oe = (r_phase == Q3);
                w_sda_oe = (r_phase == Q2) || (r_phase == Q3);
            end
            ST_RESTART: begin
                w_scl_oe = (r_phase == Q0) || (r_phase == Q3);
                w_sda_oe = (r_phase == Q2) || (r_phase == Q3);
            end
            ST_SEND_BIT: begin
                w_scl_oe = (r_phase == Q0) || (r_phase == Q3);
                w_sda_oe = !w_tx_bit;
            end
            ST_GET_ACK, ST_RECV_BIT, ST_SEND_NACK: begin
                w_scl_oe = (r_phase == Q0) || (r_phase == Q3);
            end
            ST_STOP: begin
                w_scl_oe = (r_phase == Q0);
                w_sda_oe = (r_phase == Q0) || (r_phase == Q1);
            end
            default: begin
                w_scl_oe = 1'b0;
                w_sda_oe = 1'b0;
            end
        endcase
    end

    assign o_busy    = (r_state != ST_IDLE);
    assign o_rd_data = r_rd_data;
    assign o_ack_err = r_ack_err;
    assign o_scl_oe  = w_scl_oe;
    assign o_sda_oe  = w_sda_oe;

endmodule
